// File: rtl/procesador_pkg.sv
// Shared definitions for the procesador datapath: default width, opcode enums, flag bit positions.
package procesador_pkg;

  localparam int M_DEF = 4;

  typedef enum logic [3:0] {
    G_TSF   = 4'b0000,
    G_INC   = 4'b0001,
    G_ADD   = 4'b0010,
    G_ADDC  = 4'b0011,
    G_ADDNB = 4'b0100,
    G_SUB   = 4'b0101,
    G_DEC   = 4'b0110,
    G_TSF2  = 4'b0111,
    G_AND   = 4'b1000,
    G_OR    = 4'b1001,
    G_XOR   = 4'b1010,
    G_NOT   = 4'b1011
  } g_op_t;

  typedef enum logic [1:0] {
    H_PASS = 2'b00,
    H_SHR  = 2'b01,
    H_SHL  = 2'b10,
    H_ZERO = 2'b11
  } h_op_t;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/procesador_unidad_funcional.sv
// Combinational function unit: m-bit result G plus {V,C,N,Z}.
// Arithmetic ops are A + (effective second operand) + carry-in, evaluated at m+1 bits.
module unidad_funcional
  import procesador_pkg::*;
#(
  parameter int m = M_DEF
) (
  input  logic [m-1:0] i_a,
  input  logic [m-1:0] i_b,
  input  logic [3:0]   i_sel_g,
  output logic [m-1:0] o_g,
  output logic [3:0]   o_flags
);

  logic [m-1:0] w_b_eff;
  logic         w_cin;
  logic [m:0]   w_sum;
  logic [m-1:0] w_logic;
  logic         w_c;
  logic         w_v;
  g_op_t        w_arith_op;
  g_op_t        w_logic_op;

  assign w_arith_op = g_op_t'({1'b0, i_sel_g[2:0]});
  assign w_logic_op = g_op_t'({2'b10, i_sel_g[1:0]});

  always_comb begin
    w_b_eff = '0;
    w_cin   = 1'b0;
    case (w_arith_op)
      G_INC:   w_cin = 1'b1;
      G_ADD:   w_b_eff = i_b;
      G_ADDC:  begin w_b_eff = i_b;  w_cin = 1'b1; end
      G_ADDNB: w_b_eff = ~i_b;
      G_SUB:   begin w_b_eff = ~i_b; w_cin = 1'b1; end
      G_DEC:   w_b_eff = '1;
      default: w_b_eff = '0;
    endcase
  end

  assign w_sum = {1'b0, i_a} + {1'b0, w_b_eff} + {{m{1'b0}}, w_cin};

  always_comb begin
    w_logic = '0;
    case (w_logic_op)
      G_AND:   w_logic = i_a & i_b;
      G_OR:    w_logic = i_a | i_b;
      G_XOR:   w_logic = i_a ^ i_b;
      default: w_logic = ~i_a;
    endcase
  end

  always_comb begin
    o_g = w_sum[m-1:0];
    w_c = w_sum[m];
    w_v = (i_a[m-1] == w_b_eff[m-1]) && (w_sum[m-1] != i_a[m-1]);
    if (i_sel_g[3]) begin
      o_g = w_logic;
      w_c = 1'b0;
      w_v = 1'b0;
    end
  end

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_V] = w_v;
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_N] = o_g[m-1];
    o_flags[FLAG_Z] = (o_g == '0);
  end

endmodule

// File: rtl/procesador.sv
// Mano-style datapath: 4 x m register file, function unit, shifter and MB/MF/MD muxes.
// Fully driven by an external control word; A bus is the memory address, B bus the memory data.
module procesador
  import procesador_pkg::*;
#(
  parameter int m = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   Select_A,
  input  logic [1:0]   Select_B,
  input  logic [1:0]   Select_H,
  input  logic [1:0]   Select_D,
  input  logic [m-1:0] Constant_in,
  input  logic [3:0]   Select_G,
  input  logic         Select_MB,
  input  logic         Select_MD,
  input  logic         Select_MF,
  input  logic [3:0]   Enable_load,
  input  logic [m-1:0] data_in,
  output logic [3:0]   Banderas,
  output logic [m-1:0] Out_address,
  output logic [m-1:0] Out_Data
);

  logic [m-1:0] r_regs [4];
  logic [m-1:0] w_a;
  logic [m-1:0] w_breg;
  logic [m-1:0] w_b;
  logic [m-1:0] w_g;
  logic [m-1:0] w_h;
  logic [m-1:0] w_f;
  logic [m-1:0] w_d;

  assign w_a    = r_regs[Select_A];
  assign w_breg = r_regs[Select_B];
  assign w_b    = Select_MB ? Constant_in : w_breg;

  unidad_funcional #(.m(m)) u_fu (
    .i_a     (w_a),
    .i_b     (w_b),
    .i_sel_g (Select_G),
    .o_g     (w_g),
    .o_flags (Banderas)
  );

  always_comb begin
    w_h = w_b;
    case (h_op_t'(Select_H))
      H_PASS:  w_h = w_b;
      H_SHR:   w_h = {1'b0, w_b[m-1:1]};
      H_SHL:   w_h = {w_b[m-2:0], 1'b0};
      default: w_h = '0;
    endcase
  end

  assign w_f = Select_MF ? w_h : w_g;
  assign w_d = Select_MD ? data_in : w_f;

  // Only the enable bit of the addressed register matters, so at most one write per edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (Enable_load[Select_D]) begin
      r_regs[Select_D] <= w_d;
    end
  end

  assign Out_address = w_a;
  assign Out_Data    = w_b;

endmodule

// File: tb/tb_procesador.sv
// Directed bench for procesador (m=4): vector table plus hand-written multi-cycle sequences.
module tb_procesador;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] Select_A, Select_B, Select_H, Select_D;
  logic [3:0] Constant_in, Select_G, Enable_load, data_in;
  logic       Select_MB, Select_MD, Select_MF;
  logic [3:0] Banderas, Out_address, Out_Data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [1:0] sa, sb, sd, sh;
    logic [3:0] sg;
    logic       mb, md, mf;
    logic [3:0] en, k, din;
    logic [3:0] e_addr, e_data, e_flags;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  procesador #(.m(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .Select_A    (Select_A),
    .Select_B    (Select_B),
    .Select_H    (Select_H),
    .Select_D    (Select_D),
    .Constant_in (Constant_in),
    .Select_G    (Select_G),
    .Select_MB   (Select_MB),
    .Select_MD   (Select_MD),
    .Select_MF   (Select_MF),
    .Enable_load (Enable_load),
    .data_in     (data_in),
    .Banderas    (Banderas),
    .Out_address (Out_address),
    .Out_Data    (Out_Data)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; Select_A = v.sa; Select_B = v.sb; Select_D = v.sd; Select_H = v.sh;
    Select_G = v.sg; Select_MB = v.mb; Select_MD = v.md; Select_MF = v.mf;
    Enable_load = v.en; Constant_in = v.k; data_in = v.din;
  endtask

  task automatic idle();
    rst = 1'b0; Select_A = 2'd0; Select_B = 2'd0; Select_D = 2'd0; Select_H = 2'd0;
    Select_G = 4'h0; Select_MB = 1'b0; Select_MD = 1'b0; Select_MF = 1'b0;
    Enable_load = 4'h0; Constant_in = 4'h0; data_in = 4'h0;
  endtask

  initial begin
    //                rst sa sb sd sh sg    mb md mf en       k     din    addr  data  flags
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001});
    tbl.push_back(vec_t'{0, 1, 2, 1, 0, 4'h0, 0, 1, 0, 4'b0010, 4'h0, 4'h5, 4'h0, 4'h0, 4'b0001});
    tbl.push_back(vec_t'{0, 1, 2, 2, 0, 4'h0, 0, 1, 0, 4'b0100, 4'h0, 4'h3, 4'h5, 4'h0, 4'b0000});
    tbl.push_back(vec_t'{0, 1, 2, 3, 0, 4'h2, 0, 0, 0, 4'b1000, 4'h0, 4'h0, 4'h5, 4'h3, 4'b1010});
    tbl.push_back(vec_t'{0, 3, 0, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h8, 4'h0, 4'b0010});
    tbl.push_back(vec_t'{0, 2, 2, 0, 0, 4'h5, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h3, 4'h3, 4'b0101});
    tbl.push_back(vec_t'{0, 0, 1, 0, 0, 4'h5, 1, 0, 0, 4'b0000, 4'h1, 4'h0, 4'h0, 4'h1, 4'b0010});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 4'h0, 1, 0, 0, 4'b0000, 4'hA, 4'h0, 4'h5, 4'hA, 4'b0000});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 4'b0001, 4'h0, 4'h9, 4'h0, 4'h0, 4'b0001});
    tbl.push_back(vec_t'{0, 3, 0, 3, 1, 4'h0, 0, 0, 1, 4'b1000, 4'h0, 4'h0, 4'h8, 4'h9, 4'b0010});
    tbl.push_back(vec_t'{0, 3, 0, 3, 2, 4'h0, 0, 0, 1, 4'b1000, 4'h0, 4'h0, 4'h4, 4'h9, 4'b0000});
    tbl.push_back(vec_t'{0, 3, 0, 3, 3, 4'h0, 0, 0, 1, 4'b1000, 4'h0, 4'h0, 4'h2, 4'h9, 4'b0000});
    tbl.push_back(vec_t'{0, 3, 0, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h9, 4'b0001});
    tbl.push_back(vec_t'{0, 0, 1, 0, 0, 4'h0, 0, 1, 0, 4'b1110, 4'h0, 4'hF, 4'h9, 4'h5, 4'b0010});
    tbl.push_back(vec_t'{0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h9, 4'h5, 4'b0010});
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h5, 4'h3, 4'b0000});
    tbl.push_back(vec_t'{0, 3, 2, 0, 0, 4'h0, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h3, 4'b0001});
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'hB, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h5, 4'h3, 4'b0010});
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'hC, 1, 0, 0, 4'b0000, 4'hA, 4'h0, 4'h5, 4'hA, 4'b0001});
    tbl.push_back(vec_t'{0, 3, 2, 0, 0, 4'h6, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h3, 4'b0010});
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'h6, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h5, 4'h3, 4'b0100});
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'h4, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h5, 4'h3, 4'b0100});
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'h3, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h5, 4'h3, 4'b1010});
    tbl.push_back(vec_t'{0, 1, 1, 0, 0, 4'hE, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h5, 4'h5, 4'b0001});
    tbl.push_back(vec_t'{0, 3, 3, 0, 0, 4'h9, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0001});
    tbl.push_back(vec_t'{0, 1, 2, 0, 0, 4'h9, 0, 0, 0, 4'b0000, 4'h0, 4'h0, 4'h5, 4'h3, 4'b0000});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 4'h5, 1, 0, 0, 4'b0000, 4'h3, 4'h0, 4'h9, 4'h3, 4'b1100});

    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("reset_addr", Out_address, 4'h0);
    check("reset_data", Out_Data, 4'h0);

    // Table: inputs applied at negedge, combinational outputs checked before the next rising edge.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      check($sformatf("v%0d_addr", i), Out_address, tbl[i].e_addr);
      check($sformatf("v%0d_data", i), Out_Data, tbl[i].e_data);
      check($sformatf("v%0d_flags", i), Banderas, tbl[i].e_flags);
    end

    // Same-register read/write: R0 increments, the read shows the pre-edge value.
    @(negedge clk);
    idle();
    Select_MD = 1'b1; Select_D = 2'd0; Enable_load = 4'b0001; data_in = 4'h0;
    @(negedge clk);
    idle();
    Select_A = 2'd0; Select_D = 2'd0; Select_G = 4'h1; Enable_load = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      #2;
      check($sformatf("rmw_cyc%0d", c), Out_address, 4'(c));
      @(negedge clk);
    end

    // Reset asserted while a write is pending: the write is discarded, everything clears.
    rst = 1'b1;
    #2;
    check("pre_rst_addr", Out_address, 4'h4);
    @(negedge clk);
    #2;
    check("rst_mid_addr", Out_address, 4'h0);
    @(negedge clk);
    idle();
    Select_A = 2'd1; Select_B = 2'd2;
    #2;
    check("rst_r1", Out_address, 4'h0);
    check("rst_r2", Out_Data, 4'h0);
    Select_A = 2'd3; Select_B = 2'd0;
    #2;
    check("rst_r3", Out_address, 4'h0);
    check("rst_r0", Out_Data, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
